// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS HI/LO multiply/divide unit.
// Holds the op encoding, FSM states, step modes and op-class helpers.
package mips_muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX
  } state_t;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// Single-iteration datapath: one shift-add multiply step or one restoring
// shift-subtract divide step on a {upper, lower} accumulator.
module muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  step_mode_t         mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH-1:0]   upper_next,
  output logic [WIDTH-1:0]   lower_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum        = '0;
    rem_sh     = '0;
    diff       = '0;
    upper_next = acc[2*WIDTH-1:WIDTH];
    lower_next = acc[WIDTH-1:0];
    if (mode == STEP_MUL) begin
      // Add multiplicand when the multiplier LSB is set, then shift right.
      sum        = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      upper_next = sum[WIDTH:1];
      lower_next = {sum[0], acc[WIDTH-1:1]};
    end else begin
      // Shift next dividend bit into the remainder; keep the difference if no borrow.
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = rem_sh - {1'b0, operand};
      if (!diff[WIDTH]) begin
        upper_next = diff[WIDTH-1:0];
        lower_next = {acc[WIDTH-2:0], 1'b1};
      end else begin
        upper_next = rem_sh[WIDTH-1:0];
        lower_next = {acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative HI/LO unit: MULT/MULTU/DIV/DIVU one bit per cycle, MTHI/MTLO
// in one cycle. Owns the architectural HI and LO registers.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd;
  logic [DW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;
  logic               mt_pend;

  logic               signed_op;
  logic               div_op;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [DW-1:0]      prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  step_mode_t         step_mode;
  logic [WIDTH-1:0]   upper_next;
  logic [WIDTH-1:0]   lower_next;

  // Operand magnitudes for PREP and sign-corrected results for FIX.
  always_comb begin
    signed_op = is_signed_op(op_q);
    div_op    = is_div_op(op_q);
    neg_a     = signed_op & a_q[WIDTH-1];
    neg_b     = signed_op & b_q[WIDTH-1];
    abs_a     = neg_a ? (~a_q + WIDTH'(1)) : a_q;
    abs_b     = neg_b ? (~b_q + WIDTH'(1)) : b_q;
    step_mode = div_op ? STEP_DIV : STEP_MUL;
    prod_fix  = neg_res ? (~acc + DW'(1)) : acc;
    quo_fix   = neg_res ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? (~acc[DW-1:WIDTH] + WIDTH'(1)) : acc[DW-1:WIDTH];
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode       (step_mode),
    .acc        (acc),
    .operand    (opnd),
    .upper_next (upper_next),
    .lower_next (lower_next)
  );

  // Control FSM, iteration counter and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      mt_pend     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= mt_pend;
      div_by_zero <= 1'b0;
      mt_pend     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q  <= op;
                a_q   <= src_a;
                b_q   <= src_b;
                state <= ST_PREP;
                busy  <= 1'b1;
              end
              OP_MTHI: begin
                hi      <= src_a;
                mt_pend <= 1'b1;
              end
              OP_MTLO: begin
                lo      <= src_a;
                mt_pend <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_PREP: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            neg_res <= neg_a ^ neg_b;
            neg_rem <= neg_a;
            if (div_op && (b_q == '0)) begin
              dz    <= 1'b1;
              state <= ST_FIX;
            end else begin
              dz    <= 1'b0;
              acc   <= div_op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
              opnd  <= div_op ? abs_b : abs_a;
              cnt   <= CNT_W'(WIDTH);
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= {upper_next, lower_next};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          // A flush here drops the result without signalling completion.
          if (!flush) begin
            done        <= 1'b1;
            div_by_zero <= dz;
            if (!dz) begin
              if (div_op) begin
                hi <= rem_fix;
                lo <= quo_fix;
              end else begin
                hi <= prod_fix[DW-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit at WIDTH = 32.
// Cycle k is the interval #1 after the k-th rising edge following the start edge.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in cycle 0; done must stay low until exactly cycle n.
  task automatic expect_done_at(input string tag, input int n);
    check({tag, "_c0"}, W'(done), W'(0));
    for (int k = 1; k <= n; k++) begin
      tick();
      check(tag, W'(done), W'(k == n));
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_hi",   hi, 32'h0);
    check("rst_lo",   lo, 32'h0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_dz",   W'(div_by_zero), W'(0));
    rst = 1'b0;
    tick();

    // MULT 3 * -5 = -15
    issue(OP_MULT, 32'h0000_0003, 32'hFFFF_FFFB);
    check("mult_busy0", W'(busy), W'(1));
    expect_done_at("mult_done", 34);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    check("mult_dz", W'(div_by_zero), W'(0));

    // MULTU max * max with a cycle-by-cycle busy trace
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 34; k++) begin
      tick();
      check("multu_busy", W'(busy), W'(k <= 33));
      check("multu_done", W'(done), W'(k == 34));
    end
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2: quotient -3, remainder -1
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    expect_done_at("div_neg_done", 34);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV most-negative / -1
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_done_at("div_ovf_done", 34);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);
    check("div_ovf_dz", W'(div_by_zero), W'(0));

    // MTHI / MTLO then divide by zero
    issue(OP_MTHI, 32'h0000_1234, 32'h0);
    check("mthi_busy", W'(busy), W'(0));
    check("mthi_hi", hi, 32'h0000_1234);
    expect_done_at("mthi_done", 1);
    issue(OP_MTLO, 32'h0000_5678, 32'h0);
    check("mtlo_lo", lo, 32'h0000_5678);
    expect_done_at("mtlo_done", 1);
    issue(OP_DIVU, 32'h0000_DEAD, 32'h0);
    expect_done_at("dz_done", 2);
    check("dz_flag", W'(div_by_zero), W'(1));
    check("dz_hi", hi, 32'h0000_1234);
    check("dz_lo", lo, 32'h0000_5678);

    // Back-to-back issue in the done cycle: DIVU 100 / 7
    issue(OP_DIVU, 32'd100, 32'd7);
    expect_done_at("divu_done", 34);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("divu_dz", W'(div_by_zero), W'(0));

    // Flush with start in IDLE: start wins. MULT -2 * -3 = 6
    flush = 1'b1;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    flush = 1'b0;
    expect_done_at("mult_pos_done", 34);
    check("mult_pos_hi", hi, 32'h0);
    check("mult_pos_lo", lo, 32'd6);

    // DIV 7 / -2: quotient -3, remainder 1
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    expect_done_at("div_mix_done", 34);
    check("div_mix_lo", lo, 32'hFFFF_FFFD);
    check("div_mix_hi", hi, 32'd1);

    // start(MULT) during RUN must be ignored
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    for (int k = 1; k <= 34; k++) begin
      tick();
      check("ign_done", W'(done), W'(k == 34));
      if (k == 5) begin
        op    = OP_MULT;
        src_a = 32'd2;
        src_b = 32'd3;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
    end
    check("ign_lo", lo, 32'h0FFF_FFFF);
    check("ign_hi", hi, 32'h0000_000F);

    // flush asserted in cycle 10: busy low from cycle 11, no done, HI/LO kept
    issue(OP_MULTU, 32'd2, 32'd2);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("flush_busy", W'(busy), W'(k <= 10));
      check("flush_done", W'(done), W'(0));
      if (k == 10) flush = 1'b1;
      if (k == 11) flush = 1'b0;
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      check("flush_nodone", W'(done), W'(0));
    end
    check("flush_hi", hi, 32'h0000_000F);
    check("flush_lo", lo, 32'h0FFF_FFFF);

    // Reset pulse mid-RUN clears HI/LO immediately
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("rstrun_hi", hi, 32'h0);
    check("rstrun_lo", lo, 32'h0);
    check("rstrun_busy", W'(busy), W'(0));
    tick();
    rst = 1'b0;
    tick();
    check("rstrun_done", W'(done), W'(0));

    // Reserved op: no busy, no done
    issue(3'd6, 32'd5, 32'd5);
    check("rsv_busy", W'(busy), W'(0));
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("rsv_done", W'(done), W'(0));
    end

    // Recovery after reset: MULT 0x7FFFFFFF * 2
    issue(OP_MULT, 32'h7FFF_FFFF, 32'd2);
    expect_done_at("post_done", 34);
    check("post_hi", hi, 32'h0);
    check("post_lo", lo, 32'hFFFF_FFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
